prio_scan_encoder: RTL
======================

Name: prio_scan_encoder

Overview:
- Parametrised, multi-cycle priority encoder. Converts a WIDTH-bit vector to a 1-based bit index, using the legacy encoding: bit i -> i+1, all-zero -> WIDTH+1.
- Scans the input CHUNK bits per cycle to keep the critical path short.
- Priority direction (LSB-first or MSB-first) is selectable per transaction.
- Flags inputs that are not one-hot.
- Sits between the datapath normalisation/shift logic and any consumer that needs a set-bit position. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, input vector width; must be a multiple of CHUNK and >= 2.
- CHUNK, 8, bits examined per scan cycle; must be a power of two.
- IDXW, $clog2(WIDTH+2), output index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input request valid
- in_ready  out  1  block can accept a request
- in_data  in  WIDTH  vector to encode
- in_msb_first  in  1  0 = lowest set bit wins; 1 = highest set bit wins
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_idx  out  IDXW  1-based winning bit position, or WIDTH+1 if none set
- out_found  out  1  at least one bit set
- out_multi  out  1  more than one bit set

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_idx=0, out_found=0, out_multi=0. Internal data, counter and accumulators are cleared.
- NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch in_data and in_msb_first, clear hit/multi accumulators, set chunk counter to 0, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle examines one chunk. Order: chunk 0 first for LSB-first; chunk NCHUNK-1 first for MSB-first.
  - First chunk with any bit set records the winning position: chunk base + local index per direction.
  - Later hits do not overwrite the winner. Any second set bit, in the same chunk or a later one, sets the multi accumulator.
  - All NCHUNK chunks are always scanned; there is no early exit, so latency is fixed.
  - On the edge that processes the last chunk, go to DONE and load the outputs.
- DONE:
  - out_valid=1. out_idx/out_found/out_multi are held stable while out_ready=0.
  - On out_valid && out_ready at an edge: out_valid drops and state returns to IDLE.
  - out_idx/found/multi keep their last values after the handshake; they are don't-care when out_valid=0.
- Latency: out_valid rises exactly NCHUNK rising edges after the accepting edge.
- Minimum initiation interval: NCHUNK+2 cycles. No overlap of requests; in_ready=0 in SCAN and DONE.
- All-zero input: out_idx=WIDTH+1, out_found=0, out_multi=0.
- Index arithmetic:
  - Position is computed as unsigned IDXW bits; the +1 offset is applied once, at output load.
  - No wrap: the maximum value WIDTH+1 always fits in IDXW.
- in_valid while in_ready=0 is ignored; the upstream holds it.
- in_data changes after acceptance have no effect.
- Asynchronous reset in SCAN or DONE aborts the transaction immediately: outputs go to reset values and the pending result is discarded.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Package prio_scan_pkg:
  - state enum {IDLE, SCAN, DONE}
  - function idx_width(w) = $clog2(w+2)
  - localparam for the LSB/MSB mode encoding
- One combinational sub-module, chunk_prio_enc, parametrised by CHUNK:
  - inputs: chunk bits, msb_first
  - outputs: hit, local index ($clog2(CHUNK) bits), multi-within-chunk
- The top module holds the FSM, counter, latched data and accumulators, and instantiates chunk_prio_enc once.

Test Plan (WIDTH=32, CHUNK=8):
- in_data=0x00000001, msb_first=0, accepted at edge T -> out_valid at edge T+4 with out_idx=1, found=1, multi=0.
- in_data=0x80000000, msb_first=1 -> out_idx=32, found=1, multi=0. Then in_data=0x00000000 -> out_idx=33, found=0, multi=0.
- in_data=0x00010010:
  - msb_first=0 -> out_idx=5, multi=1.
  - Same data with msb_first=1 -> out_idx=17, multi=1.
  - in_data=0x00000018 (multi inside one chunk), msb_first=0 -> out_idx=4, multi=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, out_idx, found and multi stay stable; in_ready=0; a new in_valid is ignored.
- Assert rst for 1 cycle at SCAN chunk 2 -> out_valid=0 and in_ready=1 immediately. The next request 0x00000100 yields out_idx=9, with no stale result.
- Sweep all single-bit inputs i=0..31 in both modes, back-to-back with out_ready=1 -> out_idx=i+1, multi=0. Initiation interval is measured as 6 cycles.

Source files
------------

// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the multi-cycle priority scan encoder.
//   state_t    : controller states (IDLE, SCAN, DONE)
//   MODE_*     : encoding of the in_msb_first priority-direction bit
//   idx_width  : index width able to hold the 1-based position plus the "none set" code
package prio_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

    // Holds values 0 .. w+1 (w+1 is the all-zero code).
    function automatic int unsigned idx_width(input int unsigned w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/prio_scan_encoder_if.sv
// Request/result handshake bundle for prio_scan_encoder.
//   in_valid/in_ready/in_data/in_msb_first : request channel
//   out_valid/out_ready/out_idx/out_found/out_multi : result channel
// master = requester/consumer side, slave = encoder side.
interface prio_scan_encoder_if
    import prio_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = idx_width(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_msb_first;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_found;
    logic             out_multi;

    modport master (
        output in_valid, in_data, in_msb_first, out_ready,
        input  in_ready, out_valid, out_idx, out_found, out_multi
    );

    modport slave (
        input  in_valid, in_data, in_msb_first, out_ready,
        output in_ready, out_valid, out_idx, out_found, out_multi
    );
endinterface

// File: rtl/chunk_prio_enc.sv
// Combinational priority encoder for one CHUNK-bit slice.
//   chunk     : slice under test
//   msb_first : 1 = highest set bit wins, 0 = lowest set bit wins
//   hit_c     : any bit set
//   lidx_c    : 0-based local index of the winning bit (0 when no hit)
//   multi_c   : more than one bit set in the slice
module chunk_prio_enc
    import prio_scan_pkg::*;
#(
    parameter int unsigned CHUNK = 8,
    localparam int unsigned LIDXW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             msb_first,
    output logic             hit_c,
    output logic [LIDXW-1:0] lidx_c,
    output logic             multi_c
);

    always_comb begin
        hit_c   = |chunk;
        // Clearing the lowest set bit leaves something only if a second bit exists.
        multi_c = (chunk & (chunk - CHUNK'(1))) != '0;
        lidx_c  = '0;
        // The last assignment in scan order wins, so scan away from the favoured end.
        if (msb_first == MODE_MSB) begin
            for (int i = 0; i < int'(CHUNK); i++) begin
                if (chunk[i]) lidx_c = LIDXW'(i);
            end
        end else begin
            for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
                if (chunk[i]) lidx_c = LIDXW'(i);
            end
        end
    end

endmodule

// File: rtl/prio_scan_encoder.sv
// Multi-cycle priority encoder: scans a WIDTH-bit vector CHUNK bits per cycle
// and reports the 1-based winning bit position (WIDTH+1 when no bit is set).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : request/result handshake bundle (slave side)
// Latency is fixed at NCHUNK edges after acceptance; no early exit.
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned IDXW  = idx_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    prio_scan_encoder_if.slave bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LIDXW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    state_t                        state_q, state_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [NCHUNK-1:0][CHUNK-1:0]  data_q, data_d;
    logic                          msb_q, msb_d;
    logic                          hit_q, hit_d;
    logic                          multi_q, multi_d;
    logic [IDXW-1:0]               pos_q, pos_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;
    logic [IDXW-1:0]               out_idx_q, out_idx_d;
    logic                          out_found_q, out_found_d;
    logic                          out_multi_q, out_multi_d;

    logic [CNTW-1:0]               ci_c;
    logic                          enc_hit_c;
    logic [LIDXW-1:0]              enc_lidx_c;
    logic                          enc_multi_c;

    // Physical chunk index: count up from chunk 0, or down from the top chunk.
    assign ci_c = (msb_q == MODE_MSB) ? (CNTW'(NCHUNK - 1) - cnt_q) : cnt_q;

    chunk_prio_enc #(.CHUNK(CHUNK)) u_enc (
        .chunk     (data_q[ci_c]),
        .msb_first (msb_q),
        .hit_c     (enc_hit_c),
        .lidx_c    (enc_lidx_c),
        .multi_c   (enc_multi_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        msb_d       = msb_q;
        hit_d       = hit_q;
        multi_d     = multi_q;
        pos_d       = pos_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_found_d = out_found_q;
        out_multi_d = out_multi_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d     = bus.in_data;
                    msb_d      = bus.in_msb_first;
                    hit_d      = 1'b0;
                    multi_d    = 1'b0;
                    pos_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // A hit after an earlier winner means a second set bit.
                multi_d = multi_q | enc_multi_c | (enc_hit_c & hit_q);
                if (enc_hit_c && !hit_q) begin
                    hit_d = 1'b1;
                    pos_d = IDXW'(ci_c) * IDXW'(CHUNK) + IDXW'(enc_lidx_c);
                end
                if (cnt_q == CNTW'(NCHUNK - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_found_d = hit_d;
                    out_multi_d = multi_d;
                    out_idx_d   = hit_d ? (pos_d + IDXW'(1)) : IDXW'(WIDTH + 1);
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            msb_q       <= 1'b0;
            hit_q       <= 1'b0;
            multi_q     <= 1'b0;
            pos_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_found_q <= 1'b0;
            out_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            msb_q       <= msb_d;
            hit_q       <= hit_d;
            multi_q     <= multi_d;
            pos_q       <= pos_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_found_q <= out_found_d;
            out_multi_q <= out_multi_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_found = out_found_q;
    assign bus.out_multi = out_multi_q;

endmodule
